// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - control inputs and BCD display outputs of the stopwatch
// lap exists only when LAP_HOLD_EN is defined.
interface stopwatch_bcd_if;
   logic       slowed_clk;
   logic       start_stop;
   logic       clear;
`ifdef LAP_HOLD_EN
   logic       lap;
`endif
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       wrap;

   modport master (
`ifdef LAP_HOLD_EN
      output lap,
`endif
      output slowed_clk, start_stop, clear,
      input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
   );

   modport slave (
`ifdef LAP_HOLD_EN
      input  lap,
`endif
      input  slowed_clk, start_stop, clear,
      output sec_ones, sec_tens, min_ones, min_tens, running, wrap
   );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - mm:ss BCD stopwatch counting slowed_clk rising edges
// LAP_HOLD_EN adds a lap input that freezes the displayed digits while counting continues.
module stopwatch_bcd #(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned MIN_LIMIT     = 59
) (
   input  logic           clk,
   input  logic           rst_n,
   stopwatch_bcd_if.slave bus
);
   localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);
   localparam logic [3:0] LIM_TENS  = 4'(MIN_LIMIT / 10);
   localparam logic [3:0] LIM_ONES  = 4'(MIN_LIMIT % 10);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

   state_e     state_q, state_d;
   logic       slowed_d_q;
   logic [7:0] presc_q, presc_d;
   logic [3:0] sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
   logic [3:0] min_ones_q, min_ones_d, min_tens_q, min_tens_d;
   logic       wrap_q, wrap_d;
   logic       tick, count_tick, sec_pulse;
   logic [15:0] live, shown;

   assign tick       = bus.slowed_clk & ~slowed_d_q;
   assign count_tick = tick & (state_q == RUN) & ~bus.clear;
   assign sec_pulse  = count_tick & (presc_q == PRESC_MAX);
   assign live       = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = IDLE;
      end else if (bus.start_stop) begin
         state_d = (state_q == RUN) ? PAUSE : RUN;
      end
   end

   // Carry chain resolves fully in one cycle so outputs never show a non-BCD digit.
   always_comb begin
      presc_d    = presc_q;
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      wrap_d     = 1'b0;
      if (bus.clear) begin
         presc_d    = '0;
         sec_ones_d = '0;
         sec_tens_d = '0;
         min_ones_d = '0;
         min_tens_d = '0;
      end else if (count_tick) begin
         presc_d = sec_pulse ? 8'd0 : presc_q + 8'd1;
         if (sec_pulse) begin
            if (sec_ones_q != 4'd9) begin
               sec_ones_d = sec_ones_q + 4'd1;
            end else begin
               sec_ones_d = '0;
               if (sec_tens_q != 4'd5) begin
                  sec_tens_d = sec_tens_q + 4'd1;
               end else begin
                  sec_tens_d = '0;
                  if (min_tens_q == LIM_TENS && min_ones_q == LIM_ONES) begin
                     min_ones_d = '0;
                     min_tens_d = '0;
                     wrap_d     = 1'b1;
                  end else if (min_ones_q != 4'd9) begin
                     min_ones_d = min_ones_q + 4'd1;
                  end else begin
                     min_ones_d = '0;
                     min_tens_d = min_tens_q + 4'd1;
                  end
               end
            end
         end
      end
   end

   // slowed_d resets high so a slowed_clk already high at release is not a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         slowed_d_q <= 1'b1;
         presc_q    <= '0;
         sec_ones_q <= '0;
         sec_tens_q <= '0;
         min_ones_q <= '0;
         min_tens_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         slowed_d_q <= bus.slowed_clk;
         presc_q    <= presc_d;
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
         wrap_q     <= wrap_d;
      end
   end

`ifdef LAP_HOLD_EN
   logic        hold_q, hold_d;
   logic [15:0] disp_q, disp_d;

   always_comb begin
      hold_d = hold_q;
      disp_d = disp_q;
      if (bus.clear) begin
         hold_d = 1'b0;
      end else if (bus.lap && state_q == RUN) begin
         hold_d = ~hold_q;
         if (!hold_q) begin
            disp_d = live;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 1'b0;
         disp_q <= '0;
      end else begin
         hold_q <= hold_d;
         disp_q <= disp_d;
      end
   end

   assign shown = hold_q ? disp_q : live;
`else
   assign shown = live;
`endif

   assign {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} = shown;
   assign bus.running = (state_q == RUN);
   assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - scoreboard bench for stopwatch_bcd, two parameter sets in parallel
// Instance 0: TICKS_PER_SEC=1, MIN_LIMIT=59. Instance 1: TICKS_PER_SEC=4, MIN_LIMIT=1.
module tb_stopwatch_bcd;
   logic clk;
   logic rst_n;
   logic s, ss, cl, lp;

   stopwatch_bcd_if if0 ();
   stopwatch_bcd_if if1 ();

   assign if0.slowed_clk = s;
   assign if0.start_stop = ss;
   assign if0.clear      = cl;
   assign if1.slowed_clk = s;
   assign if1.start_stop = ss;
   assign if1.clear      = cl;
`ifdef LAP_HOLD_EN
   assign if0.lap = lp;
   assign if1.lap = lp;
`endif

   stopwatch_bcd #(.TICKS_PER_SEC(1), .MIN_LIMIT(59)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   stopwatch_bcd #(.TICKS_PER_SEC(4), .MIN_LIMIT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digits;
      logic        running;
      logic        wrap;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;

   localparam int IDLE_M = 0, RUN_M = 1, PAUSE_M = 2;
   int tot[2], mode[2], presc[2], hold[2], frz[2];
   bit wrp[2];
   bit prev;

   function automatic int tps(int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic int lim(int i);
      return (i == 0) ? 59 : 1;
   endfunction

   function automatic logic [15:0] to_bcd(int t);
      int m, sec;
      m   = t / 60;
      sec = t % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         tot[i] = 0; mode[i] = IDLE_M; presc[i] = 0; hold[i] = 0; frz[i] = 0; wrp[i] = 0;
      end
      prev = 1'b1;
   endtask

   task automatic model_step(int i, bit tick);
      wrp[i] = 0;
      if (cl) begin
         tot[i] = 0; presc[i] = 0; mode[i] = IDLE_M; hold[i] = 0;
      end else begin
`ifdef LAP_HOLD_EN
         if (lp && mode[i] == RUN_M) begin
            if (hold[i] == 0) frz[i] = tot[i];
            hold[i] = 1 - hold[i];
         end
`endif
         if (mode[i] == RUN_M && tick) begin
            presc[i]++;
            if (presc[i] == tps(i)) begin
               presc[i] = 0;
               tot[i]++;
               if (tot[i] == (lim(i) + 1) * 60) begin
                  tot[i] = 0;
                  wrp[i] = 1;
               end
            end
         end
         if (ss) mode[i] = (mode[i] == RUN_M) ? PAUSE_M : RUN_M;
      end
   endtask

   function automatic exp_t expect_of(int i);
      exp_t e;
      e.digits  = to_bcd(hold[i] != 0 ? frz[i] : tot[i]);
      e.running = (mode[i] == RUN_M);
      e.wrap    = wrp[i];
      return e;
   endfunction

   task automatic step_push();
      bit tick;
      tick = s && !prev;
      model_step(0, tick);
      model_step(1, tick);
      prev = s;
      q0.push_back(expect_of(0));
      q1.push_back(expect_of(1));
   endtask

   task automatic cyc(bit s_v, bit ss_v, bit cl_v, bit lp_v);
      @(negedge clk);
      s = s_v; ss = ss_v; cl = cl_v; lp = lp_v;
      step_push();
   endtask

   task automatic edges(int n, int hi_max);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(1, hi_max)) cyc(1'b1, 1'b0, 1'b0, 1'b0);
         repeat ($urandom_range(1, hi_max)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic chk(int i, exp_t e, logic [15:0] d, logic r, logic w);
      n_vec++;
      if (d !== e.digits || r !== e.running || w !== e.wrap) begin
         n_err++;
         $display("FAIL sb%0d t=%0t got digits=%h running=%b wrap=%b expected digits=%h running=%b wrap=%b",
                  i, $time, d, r, w, e.digits, e.running, e.wrap);
      end
   endtask

   exp_t zero_e;
   initial begin
      zero_e.digits  = 16'h0000;
      zero_e.running = 1'b0;
      zero_e.wrap    = 1'b0;
   end

   task automatic chk_both(exp_t e0, exp_t e1);
      chk(0, e0, {if0.min_tens, if0.min_ones, if0.sec_tens, if0.sec_ones}, if0.running, if0.wrap);
      chk(1, e1, {if1.min_tens, if1.min_ones, if1.sec_tens, if1.sec_ones}, if1.running, if1.wrap);
   endtask

   // Monitor: pops one expected response per instance after every clock edge.
   always @(posedge clk) begin : monitor
      exp_t e0, e1;
      #1;
      if (!rst_n) begin
         chk_both(zero_e, zero_e);
      end else if (q0.size() > 0 && q1.size() > 0) begin
         e0 = q0.pop_front();
         e1 = q1.pop_front();
         chk_both(e0, e1);
      end
   end

   task automatic apply_reset(bit mid);
      if (mid) begin
         @(posedge clk);
         #3;
         rst_n = 1'b0;
         #1;
         chk_both(zero_e, zero_e);
      end else begin
         @(negedge clk);
         rst_n = 1'b0;
      end
      s = 1'b1; ss = 1'b0; cl = 1'b0; lp = 1'b0;
      model_reset();
      q0.delete();
      q1.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step_push();
   endtask

   initial begin
      rst_n = 1'b0;
      s = 1'b1; ss = 1'b0; cl = 1'b0; lp = 1'b0;
      model_reset();

      // slowed_clk high through reset release, no start: stays 00:00
      apply_reset(1'b0);
      edges(3, 3);

      // start then 12 edges
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(12, 3);

      // full-range run to the 59:59 -> 00:00 wrap
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(3599, 1);
      edges(1, 1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // start_stop coincident with a tick at 00:05 -> 00:06 paused
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(5, 2);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      edges(4, 2);

      // clear coincident with a tick at 01:30
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(90, 1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      edges(2, 2);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(9, 2);

`ifdef LAP_HOLD_EN
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(10, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      edges(5, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
`endif

      // randomized control traffic
      for (int k = 0; k < 3000; k++) begin
         cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 149) == 0), ($urandom_range(0, 24) == 0));
      end

      // asynchronous reset in the middle of a running count
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(7, 2);
      apply_reset(1'b1);
      edges(3, 2);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      edges(6, 2);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

      @(posedge clk);
      #2;
      n_vec++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d/%0d queued required 0/0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
